// File: rtl/game2048_pkg.sv
// Shared definitions for the 2048 game core, its input front end and benches.
package game2048_pkg;

  localparam logic [3:0] DIR_RIGHT  = 4'b1000;
  localparam logic [3:0] DIR_LEFT   = 4'b0100;
  localparam logic [3:0] DIR_BOTTOM = 4'b0010;
  localparam logic [3:0] DIR_TOP    = 4'b0001;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'b00,
    GS_WON     = 2'b01,
    GS_LOST    = 2'b10
  } game_state_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FIRE     = 2'b01,
    ST_WAIT_REL = 2'b10,
    ST_GAP      = 2'b11
  } in_state_t;

  // Exactly one bit set; zero is not one-hot.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer, polarity normalization and a
// stability counter that only moves the debounced level after a full quiet run.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          w_pressed;

  // Synchronizer flops rest at the released pin level so reset never looks like a press.
  assign w_pressed = r_sync ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= ACTIVE_LOW;
      r_sync <= ACTIVE_LOW;
    end else begin
      r_meta <= btn_raw;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb <= 1'b0;
      r_cnt <= {CW{1'b0}};
    end else if (w_pressed == r_deb) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      r_deb <= w_pressed;
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign deb = r_deb;

endmodule

// File: rtl/game2048_input_ctrl.sv
// Button front end for game2048: debounces four buttons and emits one
// single-cycle one-hot direction pulse per accepted press.
module game2048_input_ctrl
  import game2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GAP_CYCLES      = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic [1:0] game_state,
  output logic [3:0] direction,
  output logic       busy
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : {GW{1'b0}};

  logic [3:0]    w_deb;
  in_state_t     r_state;
  in_state_t     w_state_nxt;
  logic [3:0]    r_direction;
  logic [3:0]    w_dir_nxt;
  logic          r_busy;
  logic [GW-1:0] r_gap_cnt;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BTN_ACTIVE_LOW)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[gi]),
      .deb    (w_deb[gi])
    );
  end

  // Chords and presses outside play both park in WAIT_REL without a pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (w_deb == 4'b0000) begin
          w_state_nxt = ST_IDLE;
        end else if (is_onehot(w_deb) && (game_state == GS_PLAYING)) begin
          w_state_nxt = ST_FIRE;
          w_dir_nxt   = w_deb;
        end else begin
          w_state_nxt = ST_WAIT_REL;
        end
      end
      ST_FIRE: begin
        w_state_nxt = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (w_deb != 4'b0000) begin
          w_state_nxt = ST_WAIT_REL;
        end else if (GAP_CYCLES == 0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // busy is registered from the next state so it rises together with the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_direction <= 4'b0000;
      r_busy      <= 1'b0;
      r_gap_cnt   <= {GW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_direction <= w_dir_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      if ((r_state == ST_GAP) && (w_state_nxt == ST_GAP)) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end else begin
        r_gap_cnt <= {GW{1'b0}};
      end
    end
  end

  assign direction = r_direction;
  assign busy      = r_busy;

endmodule

// File: tb/tb_game2048_input_ctrl.sv
// Directed, table-driven bench for game2048_input_ctrl with short debounce/gap.
module tb_game2048_input_ctrl;
  import game2048_pkg::*;

  localparam int DEB = 4;
  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [1:0] game_state;
  logic [3:0] direction;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] gs;
    logic [3:0] dir;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  game2048_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .game_state(game_state),
    .direction (direction),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [3:0] d_exp, input logic b_exp);
    n_checks++;
    if (direction !== d_exp || busy !== b_exp) begin
      n_fail++;
      $display("FAIL %s: direction=%b busy=%b, expected direction=%b busy=%b",
               name, direction, busy, d_exp, b_exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic [3:0] b, input logic [1:0] g, input logic [3:0] d,
                     input logic bz, input int n);
    vec_t v;
    v.btn = b;
    v.gs  = g;
    v.dir = d;
    v.bsy = bz;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Press held 12 cycles then released: pulse (if any) six cycles after the
  // press, busy drops nine cycles after the release (5 debounce + 1 + 3 gap).
  task automatic add_press(input logic [3:0] b, input logic [1:0] g, input logic [3:0] d);
    add(b, g, 4'b0000, 1'b0, 6);
    add(b, g, d, 1'b1, 1);
    add(b, g, 4'b0000, 1'b1, 5);
    add(4'b1111, g, 4'b0000, 1'b1, 9);
    add(4'b1111, g, 4'b0000, 1'b0, 2);
  endtask

  initial begin
    int last_pulse;
    logic [3:0] d_exp;
    logic       b_exp;

    // single press right, held then released
    add_press(4'b0111, GS_PLAYING, DIR_RIGHT);
    // chord left+top, then release top only, then both
    add(4'b1010, GS_PLAYING, 4'b0000, 1'b0, 6);
    add(4'b1010, GS_PLAYING, 4'b0000, 1'b1, 4);
    add(4'b1011, GS_PLAYING, 4'b0000, 1'b1, 8);
    add(4'b1111, GS_PLAYING, 4'b0000, 1'b1, 9);
    add(4'b1111, GS_PLAYING, 4'b0000, 1'b0, 2);
    // bottom while lost: consumed silently, then bottom while playing
    add_press(4'b1101, GS_LOST, 4'b0000);
    add_press(4'b1101, GS_PLAYING, DIR_BOTTOM);
    // bounce on top: low runs of 1, 2, 3 cycles, then a solid hold
    add(4'b1110, GS_PLAYING, 4'b0000, 1'b0, 1);
    add(4'b1111, GS_PLAYING, 4'b0000, 1'b0, 1);
    add(4'b1110, GS_PLAYING, 4'b0000, 1'b0, 2);
    add(4'b1111, GS_PLAYING, 4'b0000, 1'b0, 1);
    add(4'b1110, GS_PLAYING, 4'b0000, 1'b0, 3);
    add(4'b1111, GS_PLAYING, 4'b0000, 1'b0, 1);
    add_press(4'b1110, GS_PLAYING, DIR_TOP);

    rst        = 1'b0;
    btn_raw    = 4'b1111;
    game_state = GS_PLAYING;
    #1;
    check("reset_t0", 4'b0000, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("reset_cyc%0d", c), 4'b0000, 1'b0);
    end
    rst = 1'b1;

    foreach (vecs[i]) begin
      btn_raw    = vecs[i].btn;
      game_state = vecs[i].gs;
      tick();
      check($sformatf("vec%0d", i), vecs[i].dir, vecs[i].bsy);
    end

    // Gap: left's debounced level rises while in GAP and fires only on IDLE re-entry.
    last_pulse = -1;
    for (int c = 0; c < 32; c++) begin
      btn_raw = (c < 8) ? 4'b0111 : ((c == 8) ? 4'b1111 : 4'b1011);
      tick();
      d_exp = (c == 6) ? DIR_RIGHT : ((c == 18) ? DIR_LEFT : 4'b0000);
      b_exp = (c >= 6) && (c != 17);
      check($sformatf("gap_cyc%0d", c), d_exp, b_exp);
      if (direction != 4'b0000) begin
        if (last_pulse >= 0) begin
          n_checks++;
          if (c - last_pulse < GAP + 2) begin
            n_fail++;
            $display("FAIL gap_spacing: spacing=%0d, expected at least %0d", c - last_pulse, GAP + 2);
          end
        end
        last_pulse = c;
      end
    end
    btn_raw = 4'b1111;
    for (int c = 0; c < 15; c++) tick();
    check("gap_end_idle", 4'b0000, 1'b0);

    // Reset asserted during the FIRE cycle, button kept held.
    btn_raw = 4'b0111;
    for (int c = 0; c < 7; c++) begin
      tick();
      check($sformatf("pre_rst_cyc%0d", c), (c == 6) ? DIR_RIGHT : 4'b0000, c == 6);
    end
    rst = 1'b0;
    #1;
    check("rst_async", 4'b0000, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("rst_hold%0d", c), 4'b0000, 1'b0);
    end
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("post_rst_cyc%0d", c), (c == 6) ? DIR_RIGHT : 4'b0000, c >= 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
